// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and instruction-memory signals around the IMEM port arbiter.
interface imem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 33
) ();
    // Fetch stage side
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_stall;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_flush;

    // Loader / debug side
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              hold_cpu;
    logic              cpu_held;

    // Instruction memory macro side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, hold_cpu, mem_rdata,
        output f_stall, f_rvalid, f_rdata, f_flush, l_gnt, l_rvalid, l_rdata,
               cpu_held, mem_addr, mem_we, mem_wdata
    );

    // Environment view (fetch, loader and memory)
    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, hold_cpu, mem_rdata,
        input  f_stall, f_rvalid, f_rdata, f_flush, l_gnt, l_rvalid, l_rdata,
               cpu_held, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single-port synchronous IMEM between fetch and the loader/debug port.
// Fetch has default priority; a starvation counter forces a loader grant, and
// hold_cpu gives the loader exclusive ownership with a fetch flush on release.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 33,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    imem_port_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT != 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ENTER = 2'd1,
        ST_HOLD  = 2'd2,
        ST_EXIT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOADER = 2'd2
    } owner_e;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              f_flush_q, f_flush_d;
    logic              cpu_held_q, cpu_held_d;

    logic              f_gnt_c;
    logic              l_gnt_c;
    logic              f_stall_c;
    logic              starved_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] rdata_c;

    // State, starvation counter, read owner and status flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
            f_flush_q  <= 1'b0;
            cpu_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            f_flush_q  <= f_flush_d;
            cpu_held_q <= cpu_held_d;
        end
    end

    // Arbitration, next state, counter and read-owner tracking
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        owner_d    = OWN_NONE;
        f_gnt_c    = 1'b0;
        l_gnt_c    = 1'b0;
        f_stall_c  = 1'b1;
        starved_c  = (wait_cnt_q == CNT_MAX);

        unique case (state_q)
            ST_RUN: begin
                // Arbitration still runs in the cycle hold_cpu is first seen
                if (bus.l_req && (!bus.f_req || starved_c)) begin
                    l_gnt_c = 1'b1;
                end else if (bus.f_req) begin
                    f_gnt_c = 1'b1;
                end
                f_stall_c = bus.f_req && !f_gnt_c;
                if (bus.hold_cpu) begin
                    state_d = ST_ENTER;
                end
            end
            ST_ENTER: begin
                // Drain cycle: the last RUN read returns here
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                l_gnt_c = bus.l_req;
                if (!bus.hold_cpu) begin
                    state_d = ST_EXIT;
                end
            end
            ST_EXIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Counter only ages in RUN; saturates so the compare stays an equality
        if (l_gnt_c) begin
            wait_cnt_d = '0;
        end else if ((state_q == ST_RUN) && bus.l_req && !starved_c) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end

        if (f_gnt_c) begin
            owner_d = OWN_FETCH;
        end else if (l_gnt_c && !bus.l_we) begin
            owner_d = OWN_LOADER;
        end

        f_flush_d  = (state_d == ST_EXIT);
        cpu_held_d = (state_d == ST_HOLD);
        mem_addr_c = l_gnt_c ? bus.l_addr : bus.f_addr;
    end

    assign rdata_c       = bus.mem_rdata;

    assign bus.f_stall   = f_stall_c;
    assign bus.f_rvalid  = (owner_q == OWN_FETCH);
    assign bus.f_rdata   = rdata_c;
    assign bus.f_flush   = f_flush_q;
    assign bus.l_gnt     = l_gnt_c;
    assign bus.l_rvalid  = (owner_q == OWN_LOADER);
    assign bus.l_rdata   = rdata_c;
    assign bus.cpu_held  = cpu_held_q;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_we    = l_gnt_c & bus.l_we;
    assign bus.mem_wdata = bus.l_wdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: per-cycle vector table plus reset-in-HOLD
// and STARVE_LIMIT=0 sequences. IMEM word i initialises to 33'h1_5500_0000 | i.
module tb_imem_port_arbiter;

    logic clk;
    logic rst;

    int n_chk;
    int n_fail;

    imem_port_arbiter_if #(.ADDR_W(9), .DATA_W(33)) bus ();
    imem_port_arbiter_if #(.ADDR_W(9), .DATA_W(33)) bus0 ();

    imem_port_arbiter #(.ADDR_W(9), .DATA_W(33), .STARVE_LIMIT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    imem_port_arbiter #(.ADDR_W(9), .DATA_W(33), .STARVE_LIMIT(0)) u_dut_sl0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    logic [32:0] mem  [512];
    logic [32:0] mem0 [512];

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]  = 33'h1_5500_0000 | 33'(i);
            mem0[i] = 33'h1_5500_0000 | 33'(i);
        end
    end

    // Synchronous single-port IMEM models
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clk) begin
        if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        bus0.mem_rdata <= mem0[bus0.mem_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        f_req;
        logic [8:0]  f_addr;
        logic        l_req;
        logic        l_we;
        logic [8:0]  l_addr;
        logic [32:0] l_wdata;
        logic        hold;
        logic        e_stall;
        logic        e_gnt;
        logic        e_we;
        logic [8:0]  e_maddr;
        logic        e_frv;
        logic        e_lrv;
        logic        e_flush;
        logic        e_held;
        logic [32:0] e_rdata;
    } vec_t;

    localparam int unsigned NVEC = 29;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic f_req, input logic [8:0] f_addr, input logic l_req, input logic l_we,
        input logic [8:0] l_addr, input logic [32:0] l_wdata, input logic hold,
        input logic e_stall, input logic e_gnt, input logic e_we, input logic [8:0] e_maddr,
        input logic e_frv, input logic e_lrv, input logic e_flush, input logic e_held,
        input logic [32:0] e_rdata);
        vec_t v;
        v.f_req = f_req;     v.f_addr = f_addr;   v.l_req = l_req;     v.l_we = l_we;
        v.l_addr = l_addr;   v.l_wdata = l_wdata; v.hold = hold;
        v.e_stall = e_stall; v.e_gnt = e_gnt;     v.e_we = e_we;       v.e_maddr = e_maddr;
        v.e_frv = e_frv;     v.e_lrv = e_lrv;     v.e_flush = e_flush; v.e_held = e_held;
        v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.f_req    = v.f_req;
        bus.f_addr   = v.f_addr;
        bus.l_req    = v.l_req;
        bus.l_we     = v.l_we;
        bus.l_addr   = v.l_addr;
        bus.l_wdata  = v.l_wdata;
        bus.hold_cpu = v.hold;
    endtask

    task automatic idle();
        bus.f_req = 1'b0; bus.f_addr = 9'h000; bus.l_req = 1'b0; bus.l_we = 1'b0;
        bus.l_addr = 9'h000; bus.l_wdata = 33'h0; bus.hold_cpu = 1'b0;
    endtask

    localparam logic [32:0] Z = 33'h0;
    localparam logic B0 = 1'b0;
    localparam logic B1 = 1'b1;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        idle();
        bus0.f_req = 1'b0; bus0.f_addr = 9'h000; bus0.l_req = 1'b0; bus0.l_we = 1'b0;
        bus0.l_addr = 9'h000; bus0.l_wdata = 33'h0; bus0.hold_cpu = 1'b0;

        // Columns: f_req f_addr l_req l_we l_addr l_wdata hold | stall gnt we maddr frv lrv flush held rdata
        vecs[0]  = mk(B1, 9'h000, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h000, B0, B0, B0, B0, Z);
        vecs[1]  = mk(B1, 9'h001, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h001, B1, B0, B0, B0, 33'h1_5500_0000);
        vecs[2]  = mk(B1, 9'h002, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h002, B1, B0, B0, B0, 33'h1_5500_0001);
        vecs[3]  = mk(B0, 9'h002, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h002, B1, B0, B0, B0, 33'h1_5500_0002);
        vecs[4]  = mk(B0, 9'h000, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h000, B0, B0, B0, B0, Z);
        // Starvation: fetch wins four times, loader forced on the fifth
        vecs[5]  = mk(B1, 9'h010, B1, B0, 9'h1F0, Z, B0,  B0, B0, B0, 9'h010, B0, B0, B0, B0, Z);
        vecs[6]  = mk(B1, 9'h011, B1, B0, 9'h1F0, Z, B0,  B0, B0, B0, 9'h011, B1, B0, B0, B0, 33'h1_5500_0010);
        vecs[7]  = mk(B1, 9'h012, B1, B0, 9'h1F0, Z, B0,  B0, B0, B0, 9'h012, B1, B0, B0, B0, 33'h1_5500_0011);
        vecs[8]  = mk(B1, 9'h013, B1, B0, 9'h1F0, Z, B0,  B0, B0, B0, 9'h013, B1, B0, B0, B0, 33'h1_5500_0012);
        vecs[9]  = mk(B1, 9'h014, B1, B0, 9'h1F0, Z, B0,  B1, B1, B0, 9'h1F0, B1, B0, B0, B0, 33'h1_5500_0013);
        vecs[10] = mk(B1, 9'h014, B0, B0, 9'h1F0, Z, B0,  B0, B0, B0, 9'h014, B0, B1, B0, B0, 33'h1_5500_01F0);
        // Write addr 7, read it back next cycle
        vecs[11] = mk(B0, 9'h000, B1, B1, 9'h007, 33'h0_1234_5678, B0,  B0, B1, B1, 9'h007, B1, B0, B0, B0, 33'h1_5500_0014);
        vecs[12] = mk(B0, 9'h000, B1, B0, 9'h007, Z, B0,  B0, B1, B0, 9'h007, B0, B0, B0, B0, Z);
        vecs[13] = mk(B0, 9'h000, B0, B0, 9'h007, Z, B0,  B0, B0, B0, 9'h000, B0, B1, B0, B0, 33'h0_1234_5678);
        // Hold: fetch granted on the sampling cycle, then ENTER/HOLD/EXIT
        vecs[14] = mk(B1, 9'h020, B0, B0, 9'h000, Z, B1,  B0, B0, B0, 9'h020, B0, B0, B0, B0, Z);
        vecs[15] = mk(B1, 9'h020, B1, B1, 9'h005, 33'h1_ABCD_EF00, B1,  B1, B0, B0, 9'h020, B1, B0, B0, B0, 33'h1_5500_0020);
        vecs[16] = mk(B1, 9'h020, B1, B1, 9'h005, 33'h1_ABCD_EF00, B1,  B1, B1, B1, 9'h005, B0, B0, B0, B1, Z);
        vecs[17] = mk(B0, 9'h005, B1, B0, 9'h005, Z, B1,  B1, B1, B0, 9'h005, B0, B0, B0, B1, Z);
        vecs[18] = mk(B1, 9'h005, B0, B0, 9'h005, Z, B1,  B1, B0, B0, 9'h005, B0, B1, B0, B1, 33'h1_ABCD_EF00);
        vecs[19] = mk(B1, 9'h005, B0, B0, 9'h005, Z, B0,  B1, B0, B0, 9'h005, B0, B0, B0, B1, Z);
        vecs[20] = mk(B1, 9'h005, B0, B0, 9'h005, Z, B0,  B1, B0, B0, 9'h005, B0, B0, B1, B0, Z);
        vecs[21] = mk(B1, 9'h005, B0, B0, 9'h005, Z, B0,  B0, B0, B0, 9'h005, B0, B0, B0, B0, Z);
        vecs[22] = mk(B0, 9'h000, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h000, B1, B0, B0, B0, 33'h1_ABCD_EF00);
        // hold_cpu dropped during ENTER: one HOLD cycle, then EXIT
        vecs[23] = mk(B0, 9'h000, B0, B0, 9'h000, Z, B1,  B0, B0, B0, 9'h000, B0, B0, B0, B0, Z);
        vecs[24] = mk(B0, 9'h000, B1, B0, 9'h1F0, Z, B0,  B1, B0, B0, 9'h000, B0, B0, B0, B0, Z);
        vecs[25] = mk(B0, 9'h000, B1, B0, 9'h1F0, Z, B0,  B1, B1, B0, 9'h1F0, B0, B0, B0, B1, Z);
        vecs[26] = mk(B0, 9'h000, B1, B0, 9'h007, Z, B0,  B1, B0, B0, 9'h000, B0, B1, B1, B0, 33'h1_5500_01F0);
        vecs[27] = mk(B0, 9'h000, B1, B0, 9'h007, Z, B0,  B0, B1, B0, 9'h007, B0, B0, B0, B0, Z);
        vecs[28] = mk(B0, 9'h000, B0, B0, 9'h000, Z, B0,  B0, B0, B0, 9'h000, B0, B1, B0, B0, 33'h0_1234_5678);

        // Reset state
        #12;
        chk("reset f_rvalid", 33'(bus.f_rvalid), 33'(B0));
        chk("reset l_rvalid", 33'(bus.l_rvalid), 33'(B0));
        chk("reset f_flush", 33'(bus.f_flush), 33'(B0));
        chk("reset cpu_held", 33'(bus.cpu_held), 33'(B0));
        chk("reset sl0 cpu_held", 33'(bus0.cpu_held), 33'(B0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven cycles
        for (int i = 0; i < int'(NVEC); i++) begin
            apply(vecs[i]);
            #2;
            chk($sformatf("v%0d f_stall", i), 33'(bus.f_stall), 33'(vecs[i].e_stall));
            chk($sformatf("v%0d l_gnt", i), 33'(bus.l_gnt), 33'(vecs[i].e_gnt));
            chk($sformatf("v%0d mem_we", i), 33'(bus.mem_we), 33'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 33'(bus.mem_addr), 33'(vecs[i].e_maddr));
            chk($sformatf("v%0d f_rvalid", i), 33'(bus.f_rvalid), 33'(vecs[i].e_frv));
            chk($sformatf("v%0d l_rvalid", i), 33'(bus.l_rvalid), 33'(vecs[i].e_lrv));
            chk($sformatf("v%0d f_flush", i), 33'(bus.f_flush), 33'(vecs[i].e_flush));
            chk($sformatf("v%0d cpu_held", i), 33'(bus.cpu_held), 33'(vecs[i].e_held));
            if (vecs[i].e_frv) chk($sformatf("v%0d f_rdata", i), bus.f_rdata, vecs[i].e_rdata);
            if (vecs[i].e_lrv) chk($sformatf("v%0d l_rdata", i), bus.l_rdata, vecs[i].e_rdata);
            @(posedge clk); #1;
        end

        // Reset asserted mid-HOLD with a loader read in flight
        idle();
        bus.hold_cpu = 1'b1;
        @(posedge clk); #1;                       // ENTER
        @(posedge clk); #1;                       // HOLD
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 9'h1F0;
        #2;
        chk("hold read l_gnt", 33'(bus.l_gnt), 33'(B1));
        chk("hold read cpu_held", 33'(bus.cpu_held), 33'(B1));
        #1;
        rst = 1'b0;
        idle();
        #1;
        chk("rst-in-hold cpu_held", 33'(bus.cpu_held), 33'(B0));
        chk("rst-in-hold l_rvalid", 33'(bus.l_rvalid), 33'(B0));
        chk("rst-in-hold f_flush", 33'(bus.f_flush), 33'(B0));
        chk("rst-in-hold f_stall", 33'(bus.f_stall), 33'(B0));
        #1;
        rst = 1'b1;
        @(posedge clk); #3;
        chk("after rst cpu_held", 33'(bus.cpu_held), 33'(B0));
        chk("after rst l_rvalid", 33'(bus.l_rvalid), 33'(B0));
        chk("after rst f_flush", 33'(bus.f_flush), 33'(B0));
        @(posedge clk); #1;

        // STARVE_LIMIT=0: loader always wins over fetch
        bus0.f_req = 1'b1; bus0.f_addr = 9'h040;
        bus0.l_req = 1'b1; bus0.l_we = 1'b0; bus0.l_addr = 9'h003;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("sl0 c%0d l_gnt", c), 33'(bus0.l_gnt), 33'(B1));
            chk($sformatf("sl0 c%0d f_stall", c), 33'(bus0.f_stall), 33'(B1));
            chk($sformatf("sl0 c%0d mem_addr", c), 33'(bus0.mem_addr), 33'(9'h003));
            chk($sformatf("sl0 c%0d f_rvalid", c), 33'(bus0.f_rvalid), 33'(B0));
            chk($sformatf("sl0 c%0d l_rvalid", c), 33'(bus0.l_rvalid), (c == 0) ? 33'(B0) : 33'(B1));
            if (c != 0) chk($sformatf("sl0 c%0d l_rdata", c), bus0.l_rdata, 33'h1_5500_0003);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
